spi_v3_packet_disassembler_var: RTL and testbench
=================================================

// Module: spi_v3_packet_disassembler_var
// PURPOSE
//  Parametrised successor packet disassembler for the SPI_v3 datapath.
//  - Splits one nbits_in request packet into up to NUM_CHUNKS nbits_out response chunks.
//  - Chunk count per packet is variable; order is MSB-first or LSB-first.
//  - Flags the final chunk with resp_last.
//  - Accepts the next packet in the same cycle the last chunk leaves, so back-to-back packets have no bubble.
// PARAMETERS
//  nbits_in   32  request packet width; must be >= nbits_out
//  nbits_out  8   response chunk width
//  MSB_FIRST  1   1: send the highest used chunk first; 0: send chunk 0 first
//  NUM_CHUNKS derived = ceil(nbits_in/nbits_out); do not override
//  LEN_BITS   derived = $clog2(NUM_CHUNKS+1); do not override
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  reset      in   1          asynchronous, active-high reset
//  req_val    in   1          request packet valid
//  req_rdy    out  1          disassembler can accept a packet
//  req_msg    in   nbits_in   packet to split
//  req_len    in   LEN_BITS   chunks to send; 0 or >NUM_CHUNKS saturates to NUM_CHUNKS
//  resp_val   out  1          chunk valid
//  resp_rdy   in   1          downstream accepts chunk
//  resp_msg   out  nbits_out  current chunk
//  resp_last  out  1          current chunk is the final one of its packet
// BEHAVIOUR
//  - Reset values:
//    - State IDLE; chunk regs, counter and len_q are all 0.
//    - Outputs: req_rdy=1, resp_val=0, resp_msg=0, resp_last=0.
//  - Chunk split:
//    - chunk[i] = req_msg[i*nbits_out +: nbits_out].
//    - Top chunk is zero-extended when nbits_in % nbits_out != 0.
//  - Request accept: req_val & req_rdy.
//    - Latches all chunks and len_q = saturated req_len.
//    - Clears the counter.
//    - resp_val rises the next cycle; latency is 1 cycle.
//  - FSM states IDLE and SEND:
//    - IDLE -> SEND on accept.
//    - SEND stays in SEND while chunks remain.
//    - SEND -> IDLE on a last-chunk fire with no new accept.
//    - SEND -> SEND on a last-chunk fire with a new accept; this gives back-to-back packets.
//  - Handshakes:
//    - req_rdy = (state==IDLE) | (resp_val & resp_rdy & resp_last); combinational.
//    - resp_val = (state==SEND).
//    - resp_msg and resp_last hold stable while resp_val & !resp_rdy.
//  - Chunk select, counter k = 0..len_q-1:
//    - MSB_FIRST=1: chunk index len_q-1-k, i.e. the lowest len_q chunks, highest first.
//    - MSB_FIRST=0: chunk index k.
//    - resp_last = resp_val & (k == len_q-1).
//  - Counter:
//    - Increments on each resp fire that is not the last chunk.
//    - Clears to 0 on the last fire and on accept.
//    - Never wraps past len_q-1.
//  - Simultaneous last-chunk fire and accept: the new packet's regs, len_q and k=0 take effect. No chunk is lost or duplicated.
//  - Reset mid-packet: remaining chunks are dropped and outputs return to reset values asynchronously.
//  - All arithmetic is unsigned. Mux select is truncated to $clog2(NUM_CHUNKS), minimum width 1.
// CONFIGURATION
//  - Macro SPI_V3_PKTDISASM_ABORT_EN adds port abort (in, 1).
//    - abort=1 in SEND forces IDLE next cycle and discards remaining chunks.
//    - In that cycle req_rdy=0 and any resp fire is still honoured.
//    - abort in IDLE has no effect.
//  - Without the macro: no abort port, and every packet runs to completion.
// STRUCTURE
//  - Package spi_v3_pktdisasm_pkg:
//    - state_t enum {IDLE, SEND};
//    - functions num_chunks(nin, nout) and len_bits(nchunks).
//  - One sub-module spi_v3_pktdisasm_ctrl holds the FSM, counter, len_q, req_rdy, resp_val and resp_last.
//  - Top holds the chunk registers and the output mux (vc_MuxN).
// TESTING
//  1. Defaults, msg=0xAABBCCDD, len=4, resp_rdy=1 -> AA,BB,CC,DD; resp_last on DD only; req_rdy=0 for 3 cycles.
//  2. len=2, msg=0xAABBCCDD -> CC,DD (last=1); len=0 -> 4 chunks.
//  3. MSB_FIRST=0 -> DD,CC,BB,AA.
//  4. resp_rdy toggling 1,0,0,1 -> chunk held stable while stalled.
//  5. Two packets 0x11223344 then 0x55667788, req_val held high -> 8 chunks on 8 consecutive cycles, no bubble.
//  6. nbits_in=20, nbits_out=8, msg=0xABCDE -> 0x0A,0xBC,0xDE.
//  7. Reset after 2nd chunk -> resp_val=0 at once; next packet starts at its first chunk.
//  8. With SPI_V3_PKTDISASM_ABORT_EN: abort after 1st chunk -> IDLE, req_rdy=1 next cycle.

Source files
------------

// File: rtl/spi_v3_pktdisasm_pkg.sv
// Shared types and sizing helpers for the SPI_v3 packet disassembler.
// Optional abort port is enabled by defining SPI_V3_PKTDISASM_ABORT_EN.
package spi_v3_pktdisasm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int num_chunks(input int nin, input int nout);
        return (nin + nout - 1) / nout;
    endfunction

    function automatic int len_bits(input int nchunks);
        return $clog2(nchunks + 1);
    endfunction

    // Chunk-select width; a single-chunk packet still needs a 1-bit select.
    function automatic int sel_bits(input int nchunks);
        return (nchunks > 1) ? $clog2(nchunks) : 1;
    endfunction

endpackage

// File: rtl/spi_v3_packet_disassembler_var_if.sv
// Request/response handshake bundle for the packet disassembler.
// The abort input exists only when SPI_V3_PKTDISASM_ABORT_EN is defined.
interface spi_v3_packet_disassembler_var_if #(
    parameter int nbits_in  = 32,
    parameter int nbits_out = 8
);
    localparam int LEN_BITS = spi_v3_pktdisasm_pkg::len_bits(
                                  spi_v3_pktdisasm_pkg::num_chunks(nbits_in, nbits_out));

    logic                 req_val;
    logic                 req_rdy;
    logic [nbits_in-1:0]  req_msg;
    logic [LEN_BITS-1:0]  req_len;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [nbits_out-1:0] resp_msg;
    logic                 resp_last;
`ifdef SPI_V3_PKTDISASM_ABORT_EN
    logic                 abort;
`endif

    modport slave (
        input  req_val, req_msg, req_len, resp_rdy,
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        input  abort,
`endif
        output req_rdy, resp_val, resp_msg, resp_last
    );

    modport master (
        output req_val, req_msg, req_len, resp_rdy,
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        output abort,
`endif
        input  req_rdy, resp_val, resp_msg, resp_last
    );

endinterface

// File: rtl/spi_v3_pktdisasm_ctrl.sv
// Sequencing for the disassembler: FSM, chunk counter, latched length and handshakes.
// With SPI_V3_PKTDISASM_ABORT_EN an abort in SEND drops the rest of the packet.
module spi_v3_pktdisasm_ctrl
    import spi_v3_pktdisasm_pkg::*;
#(
    parameter int NUM_CHUNKS = 4,
    parameter int LEN_BITS   = 3,
    parameter int SEL_BITS   = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_val,
    input  logic                resp_rdy,
    input  logic [LEN_BITS-1:0] req_len,
`ifdef SPI_V3_PKTDISASM_ABORT_EN
    input  logic                abort,
`endif
    output logic                req_rdy,
    output logic                resp_val,
    output logic                resp_last,
    output logic                accept,
    output logic [SEL_BITS-1:0] sel
);
    localparam logic [LEN_BITS-1:0] NUM_L = LEN_BITS'(NUM_CHUNKS);

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] k_q, k_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] len_sat;
    logic                fire;
    logic                abort_act;

    always_comb begin
        resp_val  = (state_q == SEND);
        resp_last = resp_val && (k_q == LEN_BITS'(len_q - 1'b1));
        fire      = resp_val && resp_rdy;
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        abort_act = abort && (state_q == SEND);
`else
        abort_act = 1'b0;
`endif
        // Ready early on the last fire so the next packet follows without a bubble.
        req_rdy = ((state_q == IDLE) || (fire && resp_last)) && !abort_act;
        accept  = req_val && req_rdy;
        len_sat = ((req_len == '0) || (req_len > NUM_L)) ? NUM_L : req_len;

        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        if (accept) begin
            state_d = SEND;
            k_d     = '0;
            len_d   = len_sat;
        end else if (abort_act) begin
            state_d = IDLE;
            k_d     = '0;
        end else if (fire) begin
            if (resp_last) begin
                state_d = IDLE;
                k_d     = '0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        if (MSB_FIRST != 0) begin
            sel = SEL_BITS'(len_q - k_q - 1'b1);
        end else begin
            sel = SEL_BITS'(k_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: rtl/spi_v3_packet_disassembler_var.sv
// Splits one nbits_in packet into up to NUM_CHUNKS nbits_out chunks, MSB- or LSB-first.
// Define SPI_V3_PKTDISASM_ABORT_EN to add the abort input on the interface.
module spi_v3_packet_disassembler_var
    import spi_v3_pktdisasm_pkg::*;
#(
    parameter int nbits_in  = 32,
    parameter int nbits_out = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    spi_v3_packet_disassembler_var_if.slave  io
);
    localparam int NUM_CHUNKS = num_chunks(nbits_in, nbits_out);
    localparam int LEN_BITS   = len_bits(NUM_CHUNKS);
    localparam int SEL_BITS   = sel_bits(NUM_CHUNKS);
    localparam int MUX_N      = 2 ** SEL_BITS;
    localparam int MSG_W      = NUM_CHUNKS * nbits_out;

    logic                               accept;
    logic                               resp_val;
    logic [SEL_BITS-1:0]                sel;
    logic [MSG_W-1:0]                   msg_ext;
    logic [MUX_N-1:0][nbits_out-1:0]    mux_in;

    // Zero-extends the top chunk when nbits_in is not a multiple of nbits_out.
    assign msg_ext = MSG_W'(io.req_msg);

    spi_v3_pktdisasm_ctrl #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .LEN_BITS   (LEN_BITS),
        .SEL_BITS   (SEL_BITS),
        .MSB_FIRST  (MSB_FIRST)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .req_val   (io.req_val),
        .resp_rdy  (io.resp_rdy),
        .req_len   (io.req_len),
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        .abort     (io.abort),
`endif
        .req_rdy   (io.req_rdy),
        .resp_val  (resp_val),
        .resp_last (io.resp_last),
        .accept    (accept),
        .sel       (sel)
    );

    for (genvar gi = 0; gi < MUX_N; gi++) begin : g_chunk
        if (gi < NUM_CHUNKS) begin : g_used
            logic [nbits_out-1:0] chunk_q, chunk_d;

            always_comb begin
                chunk_d = chunk_q;
                if (accept) begin
                    chunk_d = msg_ext[gi*nbits_out +: nbits_out];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chunk_q <= '0;
                end else begin
                    chunk_q <= chunk_d;
                end
            end

            assign mux_in[gi] = chunk_q;
        end else begin : g_pad
            // Unreachable select codes read as zero.
            assign mux_in[gi] = '0;
        end
    end

    assign io.resp_val = resp_val;
    assign io.resp_msg = resp_val ? mux_in[sel] : '0;

endmodule

// File: tb/tb_spi_v3_packet_disassembler_var.sv
// Directed self-checking bench: MSB-first 32/8, LSB-first 32/8 and MSB-first 20/8 instances.
// Abort scenario is compiled in when SPI_V3_PKTDISASM_ABORT_EN is defined.
module tb_spi_v3_packet_disassembler_var;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_v3_packet_disassembler_var_if #(.nbits_in(32), .nbits_out(8)) if_a ();
    spi_v3_packet_disassembler_var_if #(.nbits_in(32), .nbits_out(8)) if_b ();
    spi_v3_packet_disassembler_var_if #(.nbits_in(20), .nbits_out(8)) if_c ();

    spi_v3_packet_disassembler_var #(.nbits_in(32), .nbits_out(8), .MSB_FIRST(1)) u_dut (
        .clk(clk), .reset(reset), .io(if_a));
    spi_v3_packet_disassembler_var #(.nbits_in(32), .nbits_out(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .io(if_b));
    spi_v3_packet_disassembler_var #(.nbits_in(20), .nbits_out(8), .MSB_FIRST(1)) u_odd (
        .clk(clk), .reset(reset), .io(if_c));

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if (if_a.req_rdy !== 1'b1 || if_a.resp_val !== 1'b0 || if_a.resp_msg !== 8'h00 || if_a.resp_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b val=%b msg=%h last=%b want rdy=1 val=0 msg=00 last=0",
                     if_a.req_rdy, if_a.resp_val, if_a.resp_msg, if_a.resp_last);
        end
        $display("reset: rdy=%b val=%b msg=%h last=%b", if_a.req_rdy, if_a.resp_val, if_a.resp_msg, if_a.resp_last);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_msg = 32'hAABBCCDD; if_a.req_len = 3'd4; if_a.resp_rdy = 1'b1;
        #1;
        n_cmp++;
        if (if_a.req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_idle_rdy got %b want 1", if_a.req_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_a.req_val = 1'b0;
            #1;
            $display("basic[%0d]: val=%b msg=%h last=%b rdy=%b", i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, if_a.req_rdy);
            n_cmp++;
            if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== exp[i] || if_a.resp_last !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL basic_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, exp[i], logic'(i == 3));
            end
            n_cmp++;
            if (if_a.req_rdy !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL basic_rdy%0d got %b want %b", i, if_a.req_rdy, logic'(i == 3));
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (if_a.resp_val !== 1'b0 || if_a.req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done got val=%b rdy=%b want val=0 rdy=1", if_a.resp_val, if_a.req_rdy);
        end
    endtask

    task automatic test_len();
        logic [7:0] exp2 [2] = '{8'hCC, 8'hDD};
        logic [7:0] exp0 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_msg = 32'hAABBCCDD; if_a.req_len = 3'd2; if_a.resp_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if_a.req_val = 1'b0;
            #1;
            $display("len2[%0d]: val=%b msg=%h last=%b", i, if_a.resp_val, if_a.resp_msg, if_a.resp_last);
            n_cmp++;
            if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== exp2[i] || if_a.resp_last !== logic'(i == 1)) begin
                n_err++;
                $display("FAIL len2_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, exp2[i], logic'(i == 1));
            end
        end
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_len = 3'd0;
        #1;
        n_cmp++;
        if (if_a.resp_val !== 1'b0) begin
            n_err++;
            $display("FAIL len2_done got val=%b want 0", if_a.resp_val);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_a.req_val = 1'b0;
            #1;
            $display("len0[%0d]: val=%b msg=%h last=%b", i, if_a.resp_val, if_a.resp_msg, if_a.resp_last);
            n_cmp++;
            if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== exp0[i] || if_a.resp_last !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL len0_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, exp0[i], logic'(i == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        @(negedge clk);
        if_b.req_val = 1'b1; if_b.req_msg = 32'hAABBCCDD; if_b.req_len = 3'd4; if_b.resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_b.req_val = 1'b0;
            #1;
            $display("lsb[%0d]: val=%b msg=%h last=%b", i, if_b.resp_val, if_b.resp_msg, if_b.resp_last);
            n_cmp++;
            if (if_b.resp_val !== 1'b1 || if_b.resp_msg !== exp[i] || if_b.resp_last !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL lsb_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_b.resp_val, if_b.resp_msg, if_b.resp_last, exp[i], logic'(i == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [7:0] exp [6] = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD};
        logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_msg = 32'hAABBCCDD; if_a.req_len = 3'd4; if_a.resp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_a.req_val = 1'b0;
            if_a.resp_rdy = pat[i];
            #1;
            $display("stall[%0d]: rdy_in=%b val=%b msg=%h last=%b", i, pat[i], if_a.resp_val, if_a.resp_msg, if_a.resp_last);
            n_cmp++;
            if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== exp[i] || if_a.resp_last !== logic'(i == 5)) begin
                n_err++;
                $display("FAIL stall_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, exp[i], logic'(i == 5));
            end
        end
        if_a.resp_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_msg = 32'h11223344; if_a.req_len = 3'd4; if_a.resp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) if_a.req_msg = 32'h55667788;
            if (i == 7) if_a.req_val = 1'b0;
            #1;
            $display("b2b[%0d]: val=%b msg=%h last=%b", i, if_a.resp_val, if_a.resp_msg, if_a.resp_last);
            n_cmp++;
            if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== exp[i] || if_a.resp_last !== logic'(i == 3 || i == 7)) begin
                n_err++;
                $display("FAIL b2b_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_a.resp_val, if_a.resp_msg, if_a.resp_last, exp[i], logic'(i == 3 || i == 7));
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (if_a.resp_val !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done got val=%b want 0", if_a.resp_val);
        end
    endtask

    task automatic test_odd_width();
        logic [7:0] exp [3] = '{8'h0A, 8'hBC, 8'hDE};
        @(negedge clk);
        if_c.req_val = 1'b1; if_c.req_msg = 20'hABCDE; if_c.req_len = 2'd0; if_c.resp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_c.req_val = 1'b0;
            #1;
            $display("odd[%0d]: val=%b msg=%h last=%b", i, if_c.resp_val, if_c.resp_msg, if_c.resp_last);
            n_cmp++;
            if (if_c.resp_val !== 1'b1 || if_c.resp_msg !== exp[i] || if_c.resp_last !== logic'(i == 2)) begin
                n_err++;
                $display("FAIL odd_chunk%0d got val=%b msg=%h last=%b want val=1 msg=%h last=%b",
                         i, if_c.resp_val, if_c.resp_msg, if_c.resp_last, exp[i], logic'(i == 2));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [2] = '{8'hAA, 8'hBB};
        @(negedge clk);
        if_a.req_val = 1'b1; if_a.req_msg = 32'hAABBCCDD; if_a.req_len = 3'd4; if_a.resp_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if_a.req_val = 1'b0;
            #1;
            n_cmp++;
            if (if_a.resp_msg !== exp[i]) begin
                n_err++;
                $display("FAIL rstmid_chunk%0d got %h want %h", i, if_a.resp_msg, exp[i]);
            end
        end
        #1 reset = 1'b1;
        #1;
        $display("rstmid: val=%b msg=%h rdy=%b", if_a.resp_val, if_a.resp_msg, if_a.req_rdy);
        n_cmp++;
        if (if_a.resp_val !== 1'b0 || if_a.resp_msg !== 8'h00 || if_a.req_rdy !== 1'b1 || if_a.resp_last !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async got val=%b msg=%h rdy=%b last=%b want val=0 msg=00 rdy=1 last=0",
                     if_a.resp_val, if_a.resp_msg, if_a.req_rdy, if_a.resp_last);
        end
        @(negedge clk);
        reset = 1'b0;
        if_a.req_val = 1'b1; if_a.req_msg = 32'h01020304; if_a.req_len = 3'd4;
        @(negedge clk);
        if_a.req_val = 1'b0;
        #1;
        $display("rstmid_next: val=%b msg=%h", if_a.resp_val, if_a.resp_msg);
        n_cmp++;
        if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== 8'h01) begin
            n_err++;
            $display("FAIL rstmid_next got val=%b msg=%h want val=1 msg=01", if_a.resp_val, if_a.resp_msg);
        end
        repeat (4) @(negedge clk);
    endtask

`ifdef SPI_V3_PKTDISASM_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        if_a.abort = 1'b1; if_a.req_val = 1'b0;
        #1;
        n_cmp++;
        if (if_a.req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle_rdy got %b want 1", if_a.req_rdy);
        end
        @(negedge clk);
        if_a.abort = 1'b0;
        if_a.req_val = 1'b1; if_a.req_msg = 32'hAABBCCDD; if_a.req_len = 3'd4; if_a.resp_rdy = 1'b1;
        @(negedge clk);
        if_a.req_val = 1'b0;
        if_a.abort = 1'b1;
        #1;
        $display("abort: val=%b msg=%h rdy=%b", if_a.resp_val, if_a.resp_msg, if_a.req_rdy);
        n_cmp++;
        if (if_a.resp_val !== 1'b1 || if_a.resp_msg !== 8'hAA || if_a.req_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_cycle got val=%b msg=%h rdy=%b want val=1 msg=aa rdy=0",
                     if_a.resp_val, if_a.resp_msg, if_a.req_rdy);
        end
        @(negedge clk);
        if_a.abort = 1'b0;
        #1;
        $display("abort_after: val=%b rdy=%b", if_a.resp_val, if_a.req_rdy);
        n_cmp++;
        if (if_a.resp_val !== 1'b0 || if_a.req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_after got val=%b rdy=%b want val=0 rdy=1", if_a.resp_val, if_a.req_rdy);
        end
    endtask
`endif

    initial begin
        if_a.req_val = 1'b0; if_a.req_msg = '0; if_a.req_len = '0; if_a.resp_rdy = 1'b1;
        if_b.req_val = 1'b0; if_b.req_msg = '0; if_b.req_len = '0; if_b.resp_rdy = 1'b1;
        if_c.req_val = 1'b0; if_c.req_msg = '0; if_c.req_len = '0; if_c.resp_rdy = 1'b1;
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        if_a.abort = 1'b0; if_b.abort = 1'b0; if_c.abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_len();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_odd_width();
        test_reset_mid();
`ifdef SPI_V3_PKTDISASM_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
